// File: rtl/bfp16_mult_arbiter_if.sv
// rtl/bfp16_mult_arbiter_if.sv - request, multiplier and result signal bundle for bfp16_mult_arbiter
//
// Purpose: groups the per-requester operand ports, the shared multiplier
// connection and the result FIFO handshake into one interface.
// Ports (signals):
//   req_valid/req_a/req_b/req_ready : requester operand-pair handshake, 16 bits per slot
//   mult_a/mult_b/mult_o            : shared multiplier operands and registered product
//   res_valid/res_data/res_id/res_ready : tagged result stream
// Modports: slave = arbiter side, master = environment side.

interface bfp16_mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic [15:0]           mult_a;
    logic [15:0]           mult_b;
    logic [15:0]           mult_o;
    logic                  res_valid;
    logic [15:0]           res_data;
    logic [ID_W-1:0]       res_id;
    logic                  res_ready;

    modport slave (
        input  req_valid, req_a, req_b, mult_o, res_ready,
        output req_ready, mult_a, mult_b, res_valid, res_data, res_id
    );

    modport master (
        output req_valid, req_a, req_b, mult_o, res_ready,
        input  req_ready, mult_a, mult_b, res_valid, res_data, res_id
    );
endinterface

// File: rtl/bfp16_mult_arbiter.sv
// rtl/bfp16_mult_arbiter.sv - round-robin sharing of one BFP16 multiplier with a tagged result FIFO
//
// Purpose: picks one operand pair per cycle among NUM_REQ requesters, drives it
// onto the external multiplier, captures the product one cycle later and queues
// it with the requester index in a RES_DEPTH-entry FIFO.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : bfp16_mult_arbiter_if.slave (requests, multiplier link, result stream)
// Optional feature macro: BFP16_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest valid index wins) instead of round-robin.

module bfp16_mult_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int RES_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    bfp16_mult_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int PTR_W = $clog2(RES_DEPTH);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             s1_v_q, s1_v_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]      data_mem_q [RES_DEPTH];
    logic [15:0]      data_mem_d [RES_DEPTH];
    logic [ID_W-1:0]  id_mem_q   [RES_DEPTH];
    logic [ID_W-1:0]  id_mem_d   [RES_DEPTH];

    logic             res_valid;
    logic             pop;
    logic             push;
    logic [CNT_W:0]   occ;
    logic             can_issue;
    logic             gnt_any;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W:0]    scan;

    assign res_valid = (count_q != '0);
    assign pop       = res_valid & bus.res_ready;
    assign push      = s1_v_q;

    // Occupancy counts the in-flight product, so a slot is always reserved
    // before a pair is issued; a same-cycle pop frees a slot immediately.
    always_comb begin
        occ = (CNT_W+1)'(count_q) + (CNT_W+1)'(s1_v_q) - (CNT_W+1)'(pop);
        can_issue = (occ < (CNT_W+1)'(RES_DEPTH));
    end

    // Scan from rr_ptr upward, wrapping at NUM_REQ; first valid wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        if (can_issue && !RST) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
                if (scan >= (ID_W+1)'(NUM_REQ)) begin
                    scan = scan - (ID_W+1)'(NUM_REQ);
                end
                if (!gnt_any && bus.req_valid[scan[ID_W-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.mult_a    = 16'h0000;
        bus.mult_b    = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_any && (gnt_idx == ID_W'(i))) begin
                bus.req_ready[i] = 1'b1;
                bus.mult_a       = bus.req_a[16*i +: 16];
                bus.mult_b       = bus.req_b[16*i +: 16];
            end
        end
    end

    always_comb begin
        s1_v_d  = gnt_any;
        s1_id_d = gnt_idx;
`ifdef BFP16_ARB_FIXED_PRIO_EN
        // Fixed priority: the scan always starts at index 0.
        rr_ptr_d = '0;
`else
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
`endif
    end

    // The multiplier output is valid in the cycle after issue, so the
    // in-flight flag doubles as the FIFO push strobe.
    always_comb begin
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_mem_d = data_mem_q;
        id_mem_d   = id_mem_q;
        if (push) begin
            data_mem_d[wr_ptr_q] = bus.mult_o;
            id_mem_d[wr_ptr_q]   = s1_id_q;
            wr_ptr_d = (wr_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr_q <= '0;
            s1_v_q   <= 1'b0;
            s1_id_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                data_mem_q[i] <= 16'h0000;
                id_mem_q[i]   <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_v_q     <= s1_v_d;
            s1_id_q    <= s1_id_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_mem_q <= data_mem_d;
            id_mem_q   <= id_mem_d;
        end
    end

    assign bus.res_valid = res_valid;
    assign bus.res_data  = data_mem_q[rd_ptr_q];
    assign bus.res_id    = id_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_bfp16_mult_arbiter.sv
// tb/tb_bfp16_mult_arbiter.sv - self-checking bench for bfp16_mult_arbiter

module tb_bfp16_mult_arbiter;
    localparam int N = 4;
    localparam int IDW = 2;
    localparam int D = 2;
`ifdef BFP16_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    bfp16_mult_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

    bfp16_mult_arbiter #(.NUM_REQ(N), .ID_W(IDW), .RES_DEPTH(D)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // Truncating bfloat16 multiply for normal operands; zero exponent flushes to zero.
    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int   e;
        int   p;
        s = a[15] ^ b[15];
        if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {s, 15'h0000};
        p = int'({1'b1, a[6:0]}) * int'({1'b1, b[6:0]});
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p >= 32768) begin
            e = e + 1;
            p = p >> 8;
        end else begin
            p = p >> 7;
        end
        return {s, e[7:0], p[6:0]};
    endfunction

    // Shared multiplier stand-in: product registered one clock after operands.
    always @(posedge CLK) bus.mult_o <= bf16_mul(bus.mult_a, bus.mult_b);

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus state
    logic          rst_i;
    logic [N-1:0]  val_i;
    logic [15:0]   a_i [N];
    logic [15:0]   b_i [N];
    logic          rdy_i;

    // Reference model: outstanding products in order, plus per-ID scoreboard
    typedef struct { int id; logic [15:0] d; } ent_t;
    ent_t        fifo [$];
    bit          inf_v;
    ent_t        inf;
    int          rr;
    logic [15:0] sb [N][$];
    logic [N-1:0] last_ready;
    logic         last_rv;

    task automatic drive();
        RST = rst_i;
        bus.req_valid = val_i;
        for (int i = 0; i < N; i++) begin
            bus.req_a[16*i +: 16] = a_i[i];
            bus.req_b[16*i +: 16] = b_i[i];
        end
        bus.res_ready = rdy_i;
    endtask

    task automatic model_clear();
        fifo.delete();
        inf_v = 1'b0;
        rr = 0;
        for (int i = 0; i < N; i++) sb[i].delete();
    endtask

    task automatic run_cycle();
        logic [N-1:0] e_ready;
        logic         e_rv;
        bit           pop;
        bit           g;
        int           gid;
        int           occ;
        int           c;
        int           rid;
        logic [15:0]  e_a, e_b, sbv;
        drive();
        @(negedge CLK);
        e_rv = (fifo.size() != 0);
        pop = e_rv && rdy_i;
        occ = fifo.size() + (inf_v ? 1 : 0) - (pop ? 1 : 0);
        g = 1'b0; gid = 0; e_ready = '0; e_a = 16'h0; e_b = 16'h0;
        if (!rst_i && occ < D) begin
            for (int k = 0; k < N; k++) begin
                c = FIXED ? k : (rr + k) % N;
                if (!g && val_i[c]) begin
                    g = 1'b1;
                    gid = c;
                end
            end
        end
        if (g) begin
            e_ready[gid] = 1'b1;
            e_a = a_i[gid];
            e_b = b_i[gid];
        end
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("res_valid", 32'(bus.res_valid), 32'(e_rv));
        chk("mult_a", 32'(bus.mult_a), 32'(e_a));
        chk("mult_b", 32'(bus.mult_b), 32'(e_b));
        if (e_rv) begin
            chk("res_data", 32'(bus.res_data), 32'(fifo[0].d));
            chk("res_id", 32'(bus.res_id), 32'(fifo[0].id));
        end
        if (bus.res_valid === 1'b1 && rdy_i) begin
            rid = int'(bus.res_id);
            if (sb[rid].size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: id %0d data %h with nothing outstanding", rid, bus.res_data);
            end else begin
                sbv = sb[rid].pop_front();
                chk("sb_data", 32'(bus.res_data), 32'(sbv));
            end
        end
        if (g) sb[gid].push_back(bf16_mul(e_a, e_b));
        last_ready = bus.req_ready;
        last_rv = bus.res_valid;
        @(posedge CLK);
        if (rst_i) begin
            model_clear();
        end else begin
            if (pop) void'(fifo.pop_front());
            if (inf_v) fifo.push_back(inf);
            inf_v = g;
            inf.id = gid;
            inf.d = bf16_mul(e_a, e_b);
            if (g) rr = (gid + 1) % N;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; val_i = '0; rdy_i = 1'b0;
        drive();
        @(posedge CLK);
        #1;
        rst_i = 1'b0;
        model_clear();
    endtask

    function automatic logic [15:0] rand_op();
        logic [7:0] e;
        logic [6:0] m;
        e = 8'($urandom_range(100, 150));
        m = 7'($urandom);
        return {1'($urandom), e, m};
    endfunction

    typedef struct {
        logic         rst;
        logic [N-1:0] valid;
        logic [15:0]  a;
        logic [15:0]  b;
        logic         rdy;
        logic [N-1:0] exp_ready;
        logic         exp_rv;
        logic [15:0]  exp_data;
        logic [IDW-1:0] exp_id;
    } vec_t;

    vec_t tbl [12];
    int   sb_left;

    initial begin
        tbl[0]  = '{1'b0, 4'b0001, 16'h3F80, 16'h4000, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0};
        tbl[1]  = '{1'b0, 4'b0000, 16'h3F80, 16'h4000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
        tbl[2]  = '{1'b0, 4'b0000, 16'h3F80, 16'h4000, 1'b1, 4'b0000, 1'b1, 16'h4000, 2'd0};
        tbl[3]  = '{1'b1, 4'b1111, 16'h4040, 16'h4000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};
        tbl[4]  = '{1'b0, 4'b1111, 16'h4040, 16'h4000, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0};
        tbl[5]  = '{1'b0, 4'b1111, 16'h4040, 16'h4000, 1'b1, 4'b0010, 1'b0, 16'h0000, 2'd0};
        tbl[6]  = '{1'b0, 4'b1111, 16'h4040, 16'h4000, 1'b1, 4'b0100, 1'b1, 16'h40C0, 2'd0};
        tbl[7]  = '{1'b0, 4'b1111, 16'h4040, 16'h4000, 1'b1, 4'b1000, 1'b1, 16'h40C0, 2'd1};
        tbl[8]  = '{1'b0, 4'b1111, 16'h4040, 16'h4000, 1'b1, 4'b0001, 1'b1, 16'h40C0, 2'd2};
        tbl[9]  = '{1'b0, 4'b0000, 16'h4040, 16'h4000, 1'b1, 4'b0000, 1'b1, 16'h40C0, 2'd3};
        tbl[10] = '{1'b0, 4'b0000, 16'h4040, 16'h4000, 1'b1, 4'b0000, 1'b1, 16'h40C0, 2'd0};
        tbl[11] = '{1'b0, 4'b0000, 16'h4040, 16'h4000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0};

        // Power-up reset, then check reset state with requests pending under RST.
        rst_i = 1'b1; val_i = '0; rdy_i = 1'b0;
        for (int i = 0; i < N; i++) begin a_i[i] = 16'h0; b_i[i] = 16'h0; end
        drive();
        repeat (2) @(posedge CLK);
        #1;
        val_i = '1;
        drive();
        @(negedge CLK);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
        chk("rst_res_data", 32'(bus.res_data), 32'h0);
        chk("rst_res_id", 32'(bus.res_id), 32'h0);
        @(posedge CLK);
        #1;

        // Directed vectors: single request, reset gating, all-requester rotation.
        for (int v = 0; v < 12; v++) begin
            rst_i = tbl[v].rst;
            val_i = tbl[v].valid;
            rdy_i = tbl[v].rdy;
            for (int i = 0; i < N; i++) begin a_i[i] = tbl[v].a; b_i[i] = tbl[v].b; end
            drive();
            @(negedge CLK);
            chk($sformatf("vec%0d_req_ready", v), 32'(bus.req_ready), 32'(tbl[v].exp_ready));
            chk($sformatf("vec%0d_res_valid", v), 32'(bus.res_valid), 32'(tbl[v].exp_rv));
            if (tbl[v].exp_rv) begin
                chk($sformatf("vec%0d_res_data", v), 32'(bus.res_data), 32'(tbl[v].exp_data));
                chk($sformatf("vec%0d_res_id", v), 32'(bus.res_id), 32'(tbl[v].exp_id));
            end
            @(posedge CLK);
            #1;
        end

        // Backpressure: exactly D grants, then none until the first pop.
        do_reset();
        rdy_i = 1'b0; val_i = '1;
        begin
            int grants;
            grants = 0;
            for (int c = 0; c < 6; c++) begin
                for (int i = 0; i < N; i++) begin a_i[i] = rand_op(); b_i[i] = rand_op(); end
                run_cycle();
                grants += $countones(last_ready);
            end
            chk("bp_grant_count", 32'(grants), 32'(D));
        end
        rdy_i = 1'b1;
        run_cycle();
        chk("bp_pop_cycle_grant", 32'(last_ready), 32'b0100);
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++) begin a_i[i] = rand_op(); b_i[i] = rand_op(); end
            run_cycle();
        end
        val_i = '0;
        repeat (4) run_cycle();

        // Reset one cycle after a grant: product dropped, next grant to req0.
        do_reset();
        rdy_i = 1'b1; val_i = '1;
        for (int i = 0; i < N; i++) begin a_i[i] = rand_op(); b_i[i] = rand_op(); end
        run_cycle();
        chk("mid_first_grant", 32'(last_ready), 32'b0001);
        val_i = 4'b0010;
        run_cycle();
        rst_i = 1'b1; val_i = '1;
        run_cycle();
        rst_i = 1'b0;
        run_cycle();
        chk("mid_after_rst_valid", 32'(last_rv), 32'h0);
        chk("mid_after_rst_grant", 32'(last_ready), 32'b0001);
        val_i = '0;
        repeat (4) run_cycle();

`ifdef BFP16_ARB_FIXED_PRIO_EN
        do_reset();
        rdy_i = 1'b1; val_i = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            chk("fixed_req1_wins", 32'(last_ready), 32'b0010);
        end
        val_i = 4'b1000;
        run_cycle();
        chk("fixed_req3_next", 32'(last_ready), 32'b1000);
        val_i = '0;
        repeat (4) run_cycle();
`endif

        // Random stress against the reference model and per-ID scoreboard.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            val_i = N'($urandom);
            rdy_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin a_i[i] = rand_op(); b_i[i] = rand_op(); end
            run_cycle();
        end
        val_i = '0; rdy_i = 1'b1;
        repeat (6) run_cycle();
        sb_left = 0;
        for (int i = 0; i < N; i++) sb_left += sb[i].size();
        chk("sb_leftover", 32'(sb_left), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
